// File: rtl/rns_pkg.sv
// Shared constants and FSM state type for RNS (8,7,5,3) to binary
// conversion by mixed-radix digits.
package rns_pkg;
    localparam int M8 = 8;
    localparam int M7 = 7;
    localparam int M5 = 5;
    localparam int M3 = 3;
    localparam int M = 840;
    localparam int HALF = 420;

    localparam int W8 = 8;
    localparam int W56 = 56;
    localparam int W280 = 280;

    localparam int INV8_7 = 1;
    localparam int INV8_5 = 2;
    localparam int INV7_5 = 3;
    localparam int INV8_3 = 2;
    localparam int INV7_3 = 1;
    localparam int INV5_3 = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_D2   = 3'd1,
        ST_D3   = 3'd2,
        ST_D4   = 3'd3,
        ST_ACC  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;
endpackage

// File: rtl/rns_mrc_digit.sv
// One mixed-radix step: ((a + MOD - b) * INV) mod MOD, operands already < MOD.
module rns_mrc_digit #(
    parameter int MOD = 7,
    parameter int INV = 1,
    parameter int W   = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);
    logic [7:0] diff;
    logic [7:0] prod;

    always_comb begin
        diff = (8'(a) + 8'(MOD) - 8'(b)) % 8'(MOD);
        prod = (diff * 8'(INV)) % 8'(MOD);
        d    = W'(prod);
    end
endmodule

// File: rtl/rns2bin_mrc.sv
// RNS (8,7,5,3) to binary converter: one MRC digit per cycle, then a
// weighted sum and optional signed remap, with valid/ready on both sides.
module rns2bin_mrc
    import rns_pkg::*;
#(
    parameter bit SIGNED_OUT = 1'b1,
    parameter int OUT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mod8,
    input  logic [2:0]       mod7,
    input  logic [2:0]       mod5,
    input  logic [1:0]       mod3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             err
);
    state_t state_q, state_d;
    logic [2:0] r7_q, r7_d, r5_q, r5_d;
    logic [1:0] r3_q, r3_d;
    logic [2:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [1:0] a4_q, a4_d;
    logic err_q, err_d;
    logic out_valid_q, out_valid_d;
    logic err_out_q, err_out_d;
    logic [OUT_W-1:0] bin_out_q, bin_out_d;

    logic [2:0] a1_m7, a1_m5, a2_m5, a2_val, t5, a3_val;
    logic [1:0] a1_m3, a2_m3, a3_m3, t3a, t3b, a4_val;
    logic [9:0] x;
    logic [OUT_W-1:0] x_ext;

    // Each step subtracts earlier digits, so they are first reduced into the step's modulus.
    assign a1_m7 = 3'(a1_q % 3'd7);
    assign a1_m5 = 3'(a1_q % 3'd5);
    assign a1_m3 = 2'(a1_q % 3'd3);
    assign a2_m5 = 3'(a2_q % 3'd5);
    assign a2_m3 = 2'(a2_q % 3'd3);
    assign a3_m3 = 2'(a3_q % 3'd3);

    rns_mrc_digit #(.MOD(M7), .INV(INV8_7), .W(3)) u_d2  (.a(r7_q), .b(a1_m7), .d(a2_val));
    rns_mrc_digit #(.MOD(M5), .INV(INV8_5), .W(3)) u_d3a (.a(r5_q), .b(a1_m5), .d(t5));
    rns_mrc_digit #(.MOD(M5), .INV(INV7_5), .W(3)) u_d3b (.a(t5),   .b(a2_m5), .d(a3_val));
    rns_mrc_digit #(.MOD(M3), .INV(INV8_3), .W(2)) u_d4a (.a(r3_q), .b(a1_m3), .d(t3a));
    rns_mrc_digit #(.MOD(M3), .INV(INV7_3), .W(2)) u_d4b (.a(t3a),  .b(a2_m3), .d(t3b));
    rns_mrc_digit #(.MOD(M3), .INV(INV5_3), .W(2)) u_d4c (.a(t3b),  .b(a3_m3), .d(a4_val));

    always_comb begin
        x = 10'(a1_q) + 10'(a2_q) * 10'(W8) + 10'(a3_q) * 10'(W56) + 10'(a4_q) * 10'(W280);
        x_ext = OUT_W'(x);
    end

    always_comb begin
        state_d     = state_q;
        r7_d        = r7_q;
        r5_d        = r5_q;
        r3_d        = r3_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;
        a4_d        = a4_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        err_out_d   = err_out_q;
        bin_out_d   = bin_out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Out-of-range residues are zeroed so digit math stays in range.
                    a1_d    = mod8;
                    r7_d    = (mod7 == 3'd7) ? 3'd0 : mod7;
                    r5_d    = (mod5 > 3'd4) ? 3'd0 : mod5;
                    r3_d    = (mod3 == 2'd3) ? 2'd0 : mod3;
                    err_d   = (mod7 == 3'd7) | (mod5 > 3'd4) | (mod3 == 2'd3);
                    state_d = ST_D2;
                end
            end
            ST_D2: begin
                a2_d    = a2_val;
                state_d = ST_D3;
            end
            ST_D3: begin
                a3_d    = a3_val;
                state_d = ST_D4;
            end
            ST_D4: begin
                a4_d    = a4_val;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (err_q) begin
                    bin_out_d = '0;
                end else if (SIGNED_OUT && (x >= 10'(HALF))) begin
                    bin_out_d = x_ext - OUT_W'(M);
                end else begin
                    bin_out_d = x_ext;
                end
                err_out_d   = err_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r7_q        <= '0;
            r5_q        <= '0;
            r3_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_out_q   <= 1'b0;
            bin_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            r7_q        <= r7_d;
            r5_q        <= r5_d;
            r3_q        <= r3_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            a4_q        <= a4_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            err_out_q   <= err_out_d;
            bin_out_q   <= bin_out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign err       = err_out_q;
endmodule

// File: tb/tb_rns2bin_mrc.sv
// Directed bench: a signed and an unsigned converter share one stimulus stream.
module tb_rns2bin_mrc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [2:0] mod8 = '0, mod7 = '0, mod5 = '0;
    logic [1:0] mod3 = '0;
    logic in_ready_s, out_valid_s, err_s;
    logic in_ready_u, out_valid_u, err_u;
    logic [9:0] bin_s, bin_u;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rns2bin_mrc #(.SIGNED_OUT(1'b1), .OUT_W(10)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .mod8(mod8), .mod7(mod7), .mod5(mod5), .mod3(mod3),
        .out_valid(out_valid_s), .out_ready(out_ready), .bin_out(bin_s), .err(err_s));

    rns2bin_mrc #(.SIGNED_OUT(1'b0), .OUT_W(10)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .mod8(mod8), .mod7(mod7), .mod5(mod5), .mod3(mod3),
        .out_valid(out_valid_u), .out_ready(out_ready), .bin_out(bin_u), .err(err_u));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, input logic [1:0] d);
        @(negedge clk);
        mod8 = a; mod7 = b; mod5 = c; mod3 = d;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready_s, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid_s && lat < 12) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_drop_valid"}, out_valid_s, 0);
        chk({tag, "_ready_back"}, in_ready_s, 1);
    endtask

    task automatic convert(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [1:0] d,
                           input logic [9:0] exp_s, input logic [9:0] exp_u, input logic exp_err);
        accept(tag, a, b, c, d);
        wait_out(tag);
        chk({tag, "_bin_s"}, bin_s, exp_s);
        chk({tag, "_bin_u"}, bin_u, exp_u);
        chk({tag, "_err"}, err_s, exp_err);
        chk({tag, "_valid_u"}, out_valid_u, 1);
        release_out(tag);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready_s, 1);
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_bin", bin_s, 0);
        chk("rst_err", err_s, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        convert("zero",   3'd0, 3'd0, 3'd0, 2'd0, 10'h000, 10'd0,   1'b0);
        convert("x419",   3'd3, 3'd6, 3'd4, 2'd2, 10'h1A3, 10'd419, 1'b0);
        convert("x839",   3'd7, 3'd6, 3'd4, 2'd2, 10'h3FF, 10'd839, 1'b0);
        convert("x420",   3'd4, 3'd0, 3'd0, 2'd0, 10'h25C, 10'd420, 1'b0);
        convert("bad7",   3'd0, 3'd7, 3'd0, 2'd0, 10'h000, 10'd0,   1'b1);
        convert("one",    3'd1, 3'd1, 3'd1, 2'd1, 10'h001, 10'd1,   1'b0);
        convert("bad3",   3'd5, 3'd2, 3'd1, 2'd3, 10'h000, 10'd0,   1'b1);

        // Backpressure: result must hold while out_ready stays low.
        accept("hold", 3'd3, 3'd6, 3'd4, 2'd2);
        wait_out("hold");
        mod8 = 3'd1; mod7 = 3'd1; mod5 = 3'd1; mod3 = 2'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid_s, 1);
            chk("hold_bin", bin_s, 10'h1A3);
            chk("hold_in_ready", in_ready_s, 0);
        end
        in_valid = 1'b0;
        release_out("hold");

        // Reset lands while the next word sits in D3.
        accept("rstmid", 3'd7, 3'd6, 3'd4, 2'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_valid", out_valid_s, 0);
        chk("rstmid_in_ready", in_ready_s, 1);
        chk("rstmid_bin", bin_s, 0);
        chk("rstmid_bin_u", bin_u, 0);
        chk("rstmid_err", err_s, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1 if (out_valid_s || out_valid_u) seen = 1'b1;
            end
            chk("rstmid_no_spurious", seen, 0);
        end
        chk("rstmid_idle_ready", in_ready_s, 1);

        convert("after",  3'd7, 3'd6, 3'd4, 2'd2, 10'h3FF, 10'd839, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
